i2c_passthru_bus_recovery: RTL and testbench
============================================

# i2c_passthru_bus_recovery

Stuck-bus recovery sequencer placed directly downstream of the passthru idle/stuck detector. When the detector reports a stuck bus with SCL free and SDA held low, this block clocks up to MAX_PULSES SCL pulses until the stuck slave releases SDA. It then generates a STOP condition and reports done. If recovery cannot succeed, it reports a sticky failure.

## Interface
- F_REF_T_HALF, 38, SCL half-period and STOP setup/hold, in i_f_ref ticks
- WIDTH_F_REF_T_HALF, 6, CEILING(LOG2(F_REF_T_HALF+1))
- MAX_PULSES, 9, maximum recovery SCL pulses per attempt
- WIDTH_PULSES, 4, CEILING(LOG2(MAX_PULSES+1))

Ports:
- i_clk  in  1  system clock
- i_rstn  in  1  reset, synchronous, active-low; clock i_clk
- i_f_ref  in  1  timing reference; its rising edge (i_clk-sampled) is one tick
- i_stuck  in  1  stuck flag from the detector
- i_idle  in  1  bus idle flag from the detector
- i_sda  in  1  synchronised SDA bus level
- i_scl  in  1  synchronised SCL bus level
- o_scl_drive_low  out  1  1 = pull SCL low
- o_sda_drive_low  out  1  1 = pull SDA low
- o_busy  out  1  recovery in progress (every state except ST_WAIT and ST_FAIL)
- o_done  out  1  single-cycle pulse on successful STOP completion
- o_fail  out  1  sticky recovery failure

## Operation
- Internal registers:
  - prev_f_ref and prev_stuck, for rising-edge detection.
  - A down-counter timer of width WIDTH_F_REF_T_HALF:
    - Loaded with F_REF_T_HALF on every state entry.
    - Decrements on each f_ref tick.
    - tc means the count equals 0; the timer holds at 0.
  - A pulse_cnt register of width WIDTH_PULSES.
- ST_WAIT: both drives released.
  - On a rising edge of i_stuck with o_fail = 0: if i_scl = 0, go to ST_FAIL; otherwise clear pulse_cnt and go to ST_SCL_LOW.
  - A rising edge of i_stuck while o_fail = 1 is ignored.
- ST_SCL_LOW: o_scl_drive_low = 1. On tc, go to ST_SCL_HIGH.
- ST_SCL_HIGH: both drives released. On tc, sample i_sda:
  - i_sda = 1: go to ST_STOP_PRE.
  - i_sda = 0 and pulse_cnt+1 == MAX_PULSES: go to ST_FAIL.
  - Otherwise: pulse_cnt += 1 and go to ST_SCL_LOW.
- ST_STOP_PRE: SCL and SDA both driven low. On tc, go to ST_STOP_SCL.
- ST_STOP_SCL: SCL released, SDA still driven low. On tc, go to ST_STOP_SDA.
- ST_STOP_SDA: both released.
  - On tc: o_done = 1 for that cycle; go to ST_WAIT.
  - If i_sda = 0 at tc, the STOP failed: go to ST_FAIL instead, with no o_done.
- ST_FAIL: both drives released; o_fail = 1.
  - Exit to ST_WAIT, with o_fail cleared, on the first cycle with i_idle = 1.
- Any unused state encoding goes to ST_WAIT.
- pulse_cnt never exceeds MAX_PULSES-1; no wrap-around is possible.
- Re-stuck after ST_DONE: the detector re-asserts i_stuck after its own timeout. The resulting new rising edge starts a fresh attempt.

## Timing
- Reset: the first i_clk edge with i_rstn = 0 clears all outputs to 0 and state to ST_WAIT. This applies mid-sequence too, so drives release one cycle after reset is sampled.
- Trigger latency:
  - Edge sampled: the i_stuck rising edge is detected on cycle N.
  - First SCL drive: o_scl_drive_low = 1 from cycle N+1.
- All outputs are registered.
- One SCL low phase lasts F_REF_T_HALF ticks (±1 i_clk cycle for tick phase).
- A tick coincident with a state change is consumed by the new state's load. Load wins over decrement.
- i_stuck deasserting mid-sequence does not abort; the detector clears stuck on our own edges.
- Simultaneous i_idle = 1 and an i_stuck edge in ST_FAIL: exit to ST_WAIT; the edge is not consumed.

## Configuration
- I2C_PASSTHRU_RECOVERY_STRETCH_EN:
  - Defined: in ST_SCL_HIGH and ST_STOP_SCL the timer decrements only while i_scl = 1, so clock stretching extends the high phase. If SCL remains low for 2×F_REF_T_HALF ticks in either state, go to ST_FAIL.
  - Undefined: the timer decrements regardless of i_scl, and there is no stretch fail path.

## Test plan
- SDA held low, released after the 3rd SCL rising edge (F_REF_T_HALF=4, f_ref every 2 clocks):
  - Exactly 3 SCL low pulses.
  - Then STOP: SDA low→SCL release→SDA release.
  - o_done pulses once, o_busy drops the same cycle, o_fail = 0.
- SDA never released:
  - 9 SCL pulses, then o_fail = 1 with both drives 0.
  - i_idle = 1 for one cycle → o_fail = 0 the next cycle.
- i_scl = 0 when i_stuck rises: ST_FAIL the next cycle with zero SCL pulses driven.
- i_rstn = 0 asserted during ST_STOP_PRE:
  - One cycle later, both drives, o_busy, o_done and o_fail are 0.
  - After reset release, an i_stuck that is already high does not trigger.
- i_stuck rising while o_fail = 1: no drive activity; state stays ST_FAIL.
- With STRETCH_EN, SCL held low by the bench for 3 ticks in ST_SCL_HIGH: the high phase lengthens by 3 ticks. Holding it for 8 ticks (2×4) gives o_fail = 1.

Source files
------------

// File: rtl/i2c_passthru_bus_recovery.sv
// i2c_passthru_bus_recovery
// Stuck-bus recovery sequencer. When the detector flags a stuck bus with SCL
// free, it clocks up to MAX_PULSES SCL pulses until SDA is released. It then
// issues a STOP and pulses o_done, or it raises a sticky o_fail.
// Optional feature: define I2C_PASSTHRU_RECOVERY_STRETCH_EN to honour slave
// clock stretching in the SCL-high and STOP-SCL phases. A stretch that lasts
// 2*F_REF_T_HALF ticks is treated as a failure.
module i2c_passthru_bus_recovery #(
    parameter int F_REF_T_HALF       = 38,
    parameter int WIDTH_F_REF_T_HALF = 6,
    parameter int MAX_PULSES         = 9,
    parameter int WIDTH_PULSES       = 4
) (
    input  logic i_clk,
    input  logic i_rstn,
    input  logic i_f_ref,
    input  logic i_stuck,
    input  logic i_idle,
    input  logic i_sda,
    input  logic i_scl,
    output logic o_scl_drive_low,
    output logic o_sda_drive_low,
    output logic o_busy,
    output logic o_done,
    output logic o_fail
);

    typedef enum logic [2:0] {
        ST_WAIT     = 3'd0,
        ST_SCL_LOW  = 3'd1,
        ST_SCL_HIGH = 3'd2,
        ST_STOP_PRE = 3'd3,
        ST_STOP_SCL = 3'd4,
        ST_STOP_SDA = 3'd5,
        ST_FAIL     = 3'd6
    } state_e;

    localparam logic [WIDTH_F_REF_T_HALF-1:0] TIMER_LOAD = WIDTH_F_REF_T_HALF'(F_REF_T_HALF);
    localparam logic [WIDTH_PULSES-1:0]       PULSE_LAST = WIDTH_PULSES'(MAX_PULSES - 1);

    state_e                        state_q, state_d;
    logic                          prev_f_ref_q;
    logic                          prev_stuck_q;
    logic [WIDTH_F_REF_T_HALF-1:0] timer_q, timer_d;
    logic [WIDTH_PULSES-1:0]       pulse_cnt_q, pulse_cnt_d;
    logic                          scl_drive_low_q, scl_drive_low_d;
    logic                          sda_drive_low_q, sda_drive_low_d;
    logic                          busy_q, busy_d;
    logic                          done_q, done_d;
    logic                          fail_q, fail_d;

    logic f_ref_tick;
    logic stuck_rise;
    logic tc;
    logic stretch_hold;
    logic stretch_fail;

    assign f_ref_tick = i_f_ref & ~prev_f_ref_q;
    assign stuck_rise = i_stuck & ~prev_stuck_q;
    assign tc         = (timer_q == '0);

`ifdef I2C_PASSTHRU_RECOVERY_STRETCH_EN
    localparam int                       WIDTH_STRETCH = WIDTH_F_REF_T_HALF + 1;
    localparam logic [WIDTH_STRETCH-1:0] STRETCH_LIMIT = WIDTH_STRETCH'(2 * F_REF_T_HALF);

    logic [WIDTH_STRETCH-1:0] stretch_cnt_q, stretch_cnt_d;
    logic                     stretch_state;

    // A slave holding SCL low in a released-SCL phase freezes the timer
    assign stretch_state = (state_q == ST_SCL_HIGH) || (state_q == ST_STOP_SCL);
    assign stretch_hold  = stretch_state & ~i_scl;
    assign stretch_fail  = stretch_state && (stretch_cnt_q == STRETCH_LIMIT);

    // Count consecutive ticks of SCL held low; any SCL high or state change restarts it
    always_comb begin
        stretch_cnt_d = stretch_cnt_q;
        if ((state_d != state_q) || !stretch_hold) begin
            stretch_cnt_d = '0;
        end else if (f_ref_tick && (stretch_cnt_q != STRETCH_LIMIT)) begin
            stretch_cnt_d = stretch_cnt_q + 1'b1;
        end
    end
`else
    assign stretch_hold = 1'b0;
    assign stretch_fail = 1'b0;
`endif

    // Next-state and pulse bookkeeping for the recovery sequence
    always_comb begin
        // NOTE: every always_comb output gets a default first so no path can infer a latch.
        state_d     = state_q;
        pulse_cnt_d = pulse_cnt_q;
        done_d      = 1'b0;
        case (state_q)
            ST_WAIT: begin
                if (stuck_rise) begin
                    if (!i_scl) begin
                        state_d = ST_FAIL;
                    end else begin
                        pulse_cnt_d = '0;
                        state_d     = ST_SCL_LOW;
                    end
                end
            end
            ST_SCL_LOW: begin
                if (tc) state_d = ST_SCL_HIGH;
            end
            ST_SCL_HIGH: begin
                if (stretch_fail) begin
                    state_d = ST_FAIL;
                end else if (tc) begin
                    if (i_sda) begin
                        state_d = ST_STOP_PRE;
                    end else if (pulse_cnt_q == PULSE_LAST) begin
                        state_d = ST_FAIL;
                    end else begin
                        pulse_cnt_d = pulse_cnt_q + 1'b1;
                        state_d     = ST_SCL_LOW;
                    end
                end
            end
            ST_STOP_PRE: begin
                if (tc) state_d = ST_STOP_SCL;
            end
            ST_STOP_SCL: begin
                if (stretch_fail) begin
                    state_d = ST_FAIL;
                end else if (tc) begin
                    state_d = ST_STOP_SDA;
                end
            end
            ST_STOP_SDA: begin
                if (tc) begin
                    if (i_sda) begin
                        done_d  = 1'b1;
                        state_d = ST_WAIT;
                    end else begin
                        state_d = ST_FAIL;
                    end
                end
            end
            ST_FAIL: begin
                if (i_idle) state_d = ST_WAIT;
            end
            default: state_d = ST_WAIT;
        endcase
    end

    // Phase timer: reload on every state entry (load beats a coincident tick), else count ticks down to 0
    always_comb begin
        timer_d = timer_q;
        if (state_d != state_q) begin
            timer_d = TIMER_LOAD;
        end else if (f_ref_tick && !tc && !stretch_hold) begin
            timer_d = timer_q - 1'b1;
        end
    end

    // Output decode from the next state so the registered outputs line up with state_q
    always_comb begin
        scl_drive_low_d = (state_d == ST_SCL_LOW) || (state_d == ST_STOP_PRE);
        sda_drive_low_d = (state_d == ST_STOP_PRE) || (state_d == ST_STOP_SCL);
        busy_d          = (state_d != ST_WAIT) && (state_d != ST_FAIL);
        fail_d          = (state_d == ST_FAIL);
    end

    // State, timer, counters, edge history and registered outputs
    always_ff @(posedge i_clk) begin
        if (!i_rstn) begin
            state_q         <= ST_WAIT;
            // NOTE: edge history tracks the inputs during reset, so a level that is already high at release is not an edge.
            prev_f_ref_q    <= i_f_ref;
            prev_stuck_q    <= i_stuck;
            timer_q         <= TIMER_LOAD;
            pulse_cnt_q     <= '0;
            scl_drive_low_q <= 1'b0;
            sda_drive_low_q <= 1'b0;
            busy_q          <= 1'b0;
            done_q          <= 1'b0;
            fail_q          <= 1'b0;
`ifdef I2C_PASSTHRU_RECOVERY_STRETCH_EN
            stretch_cnt_q   <= '0;
`endif
        end else begin
            state_q         <= state_d;
            prev_f_ref_q    <= i_f_ref;
            prev_stuck_q    <= i_stuck;
            timer_q         <= timer_d;
            pulse_cnt_q     <= pulse_cnt_d;
            scl_drive_low_q <= scl_drive_low_d;
            sda_drive_low_q <= sda_drive_low_d;
            busy_q          <= busy_d;
            done_q          <= done_d;
            fail_q          <= fail_d;
`ifdef I2C_PASSTHRU_RECOVERY_STRETCH_EN
            stretch_cnt_q   <= stretch_cnt_d;
`endif
        end
    end

    assign o_scl_drive_low = scl_drive_low_q;
    assign o_sda_drive_low = sda_drive_low_q;
    assign o_busy          = busy_q;
    assign o_done          = done_q;
    assign o_fail          = fail_q;

endmodule

// File: tb/tb_i2c_passthru_bus_recovery.sv
// tb_i2c_passthru_bus_recovery
// Directed bench for the stuck-bus recovery sequencer. The DUT runs with
// F_REF_T_HALF=4 and one f_ref tick every 2 clocks. Open-drain SCL/SDA are
// modelled from the drive outputs, together with a slave that holds SDA low
// until a given number of SCL rising edges have been seen.
`timescale 1ns/1ps
module tb_i2c_passthru_bus_recovery;

    localparam int T_HALF = 4;

    logic clk   = 1'b0;
    logic rstn  = 1'b0;
    logic f_ref = 1'b0;
    logic stuck = 1'b0;
    logic idle  = 1'b0;
    logic scl_hold    = 1'b0;
    logic slave_stuck = 1'b0;
    int   release_after = 0;
    int   rise_base     = 0;

    logic scl, sda;
    logic scl_drv, sda_drv, busy, done, fail;

    int compared   = 0;
    int mismatched = 0;

    // Monitor state: written only by the monitor process
    int         scl_pulses   = 0;
    int         scl_rises    = 0;
    int         done_cnt     = 0;
    int         drive_cycles = 0;
    logic       busy_at_done = 1'b0;
    logic       tick_mon     = 1'b0;
    logic       fref_prev    = 1'b0;
    logic       scl_prev     = 1'b0;
    logic [1:0] last_combo   = 2'b00;
    logic [1:0] trace[$];

    assign scl = ~scl_drv & ~scl_hold;
    assign sda = ~sda_drv & ~(slave_stuck & ((scl_rises - rise_base) < release_after));

    i2c_passthru_bus_recovery #(
        .F_REF_T_HALF       (T_HALF),
        .WIDTH_F_REF_T_HALF (3),
        .MAX_PULSES         (9),
        .WIDTH_PULSES       (4)
    ) dut (
        .i_clk           (clk),
        .i_rstn          (rstn),
        .i_f_ref         (f_ref),
        .i_stuck         (stuck),
        .i_idle          (idle),
        .i_sda           (sda),
        .i_scl           (scl),
        .o_scl_drive_low (scl_drv),
        .o_sda_drive_low (sda_drv),
        .o_busy          (busy),
        .o_done          (done),
        .o_fail          (fail)
    );

    always #5 clk = ~clk;

    // f_ref toggles every clock: one rising edge, i.e. one tick, every 2 clocks
    always @(negedge clk) f_ref = ~f_ref;

    // Monitor just after each active edge: ticks, SCL pulses, done pulses, drive trace
    always @(posedge clk) begin
        #1;
        tick_mon  = f_ref & ~fref_prev;
        fref_prev = f_ref;
        if (scl_drv && !scl_prev && !sda_drv) scl_pulses++;
        if (!scl_drv && scl_prev && !sda_drv) scl_rises++;
        scl_prev = scl_drv;
        if (scl_drv || sda_drv) drive_cycles++;
        if (done) begin
            done_cnt++;
            busy_at_done = busy;
        end
        if ({scl_drv, sda_drv} != last_combo) begin
            trace.push_back({scl_drv, sda_drv});
            last_combo = {scl_drv, sda_drv};
        end
    end

    task automatic check(input string tag, input int got, input int exp);
        compared++;
        if (got !== exp) begin
            mismatched++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic cycles(input int n);
        repeat (n) @(negedge clk);
    endtask

    // Wait at negedges for o_done or o_fail; an expired budget counts as a failure
    task automatic wait_end(input string tag, input int budget);
        int k = 0;
        while (!(done || fail) && (k < budget)) begin
            @(negedge clk);
            k++;
        end
        if (!(done || fail)) check(tag, 0, 1);
    endtask

    task automatic pulse_idle();
        idle = 1'b1;
        @(negedge clk);
        idle = 1'b0;
    endtask

`ifdef I2C_PASSTHRU_RECOVERY_STRETCH_EN
    // Start an attempt and return #2 after the edge that enters the first SCL-high phase
    task automatic enter_first_high(input int rel);
        int k = 0;
        stuck         = 1'b0;
        slave_stuck   = 1'b1;
        release_after = rel;
        rise_base     = scl_rises;
        cycles(2);
        stuck = 1'b1;
        while (!scl_drv && (k < 100)) begin @(posedge clk); #2; k++; end
        while (scl_drv && (k < 200)) begin @(posedge clk); #2; k++; end
    endtask

    // Count ticks in the first SCL-high phase while SCL is held low for hold_ticks ticks
    task automatic measure_high(input int hold_ticks, output int ticks);
        int held = 0;
        int k    = 0;
        ticks = 0;
        enter_first_high(1);
        if (hold_ticks > 0) scl_hold = 1'b1;
        while (k < 200) begin
            @(posedge clk); #2;
            k++;
            if (scl_drv || sda_drv) break;
            if (tick_mon) begin
                ticks++;
                if (scl_hold) begin
                    held++;
                    if (held == hold_ticks) scl_hold = 1'b0;
                end
            end
        end
        scl_hold = 1'b0;
    endtask
`endif

    initial begin
        int pb, db, dc, k;
        logic [1:0] t0, t1, t2;

        // Reset state
        rstn = 1'b0;
        cycles(3);
        check("rst_scl_drv", int'(scl_drv), 0);
        check("rst_sda_drv", int'(sda_drv), 0);
        check("rst_busy",    int'(busy),    0);
        check("rst_done",    int'(done),    0);
        check("rst_fail",    int'(fail),    0);
        rstn = 1'b1;
        cycles(2);
        check("idle_busy", int'(busy), 0);

        // Slave releases SDA after the 3rd SCL rising edge
        slave_stuck   = 1'b1;
        release_after = 3;
        rise_base     = scl_rises;
        pb = scl_pulses;
        db = done_cnt;
        stuck = 1'b1;
        @(negedge clk);
        check("trig_scl_drv", int'(scl_drv), 1);
        check("trig_busy",    int'(busy),    1);
        wait_end("t1_timeout", 1000);
        check("t1_done",         int'(done), 1);
        check("t1_busy_at_done", int'(busy), 0);
        cycles(3);
        check("t1_scl_pulses", scl_pulses - pb, 3);
        check("t1_done_count", done_cnt - db,   1);
        check("t1_busy_flag",  int'(busy_at_done), 0);
        check("t1_fail",       int'(fail), 0);
        t0 = trace[trace.size() - 3];
        t1 = trace[trace.size() - 2];
        t2 = trace[trace.size() - 1];
        check("t1_stop_pre", int'(t0), 2'b11);
        check("t1_stop_scl", int'(t1), 2'b01);
        check("t1_stop_sda", int'(t2), 2'b00);
        stuck       = 1'b0;
        slave_stuck = 1'b0;
        cycles(3);

        // SDA never released: 9 pulses, then failure
        slave_stuck   = 1'b1;
        release_after = 100;
        rise_base     = scl_rises;
        pb = scl_pulses;
        db = done_cnt;
        stuck = 1'b1;
        wait_end("t2_timeout", 2000);
        check("t2_fail",       int'(fail), 1);
        check("t2_scl_pulses", scl_pulses - pb, 9);
        check("t2_scl_drv",    int'(scl_drv), 0);
        check("t2_sda_drv",    int'(sda_drv), 0);
        check("t2_busy",       int'(busy), 0);
        check("t2_no_done",    done_cnt - db, 0);
        // A new stuck edge while failed is ignored
        stuck = 1'b0;
        cycles(3);
        dc = drive_cycles;
        stuck = 1'b1;
        cycles(20);
        check("t2_retrig_drive", drive_cycles - dc, 0);
        check("t2_retrig_fail",  int'(fail), 1);
        pulse_idle();
        check("t2_idle_clears", int'(fail), 0);
        slave_stuck = 1'b0;
        stuck       = 1'b0;

        // SCL low when stuck rises: straight to failure, no pulses
        scl_hold = 1'b1;
        cycles(2);
        pb = scl_pulses;
        stuck = 1'b1;
        @(negedge clk);
        check("t3_fail",    int'(fail),    1);
        check("t3_busy",    int'(busy),    0);
        check("t3_scl_drv", int'(scl_drv), 0);
        cycles(5);
        check("t3_no_pulses", scl_pulses - pb, 0);
        scl_hold = 1'b0;
        pulse_idle();
        check("t3_idle_clears", int'(fail), 0);
        stuck = 1'b0;

        // Reset during the STOP setup phase
        slave_stuck   = 1'b1;
        release_after = 1;
        rise_base     = scl_rises;
        cycles(2);
        stuck = 1'b1;
        k = 0;
        while (!(scl_drv && sda_drv) && (k < 500)) begin
            @(negedge clk);
            k++;
        end
        check("t4_reached_stop_pre", int'(scl_drv && sda_drv), 1);
        rstn = 1'b0;
        @(negedge clk);
        check("t4_scl_drv", int'(scl_drv), 0);
        check("t4_sda_drv", int'(sda_drv), 0);
        check("t4_busy",    int'(busy),    0);
        check("t4_done",    int'(done),    0);
        check("t4_fail",    int'(fail),    0);
        cycles(2);
        rstn = 1'b1;
        dc = drive_cycles;
        cycles(40);
        check("t4_no_retrigger", drive_cycles - dc, 0);
        check("t4_busy_after",   int'(busy), 0);
        slave_stuck = 1'b0;

`ifdef I2C_PASSTHRU_RECOVERY_STRETCH_EN
        begin
            int ht;
            measure_high(0, ht);
            check("stretch_base_ticks", ht, T_HALF);
            wait_end("stretch_base_end", 500);
            measure_high(3, ht);
            check("stretch_3_ticks", ht, T_HALF + 3);
            wait_end("stretch_3_end", 500);
            check("stretch_3_done", int'(done), 1);
            // SCL held low for 2*T_HALF ticks in the high phase
            enter_first_high(100);
            scl_hold = 1'b1;
            wait_end("stretch_fail_timeout", 200);
            check("stretch_fail", int'(fail), 1);
            scl_hold = 1'b0;
            pulse_idle();
            check("stretch_fail_clears", int'(fail), 0);
            stuck       = 1'b0;
            slave_stuck = 1'b0;
        end
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

    // Global time limit
    initial begin
        #500000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "bench time limit reached");
    end

endmodule
